// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, RV32I opcode fields and issue FSM states
package alu_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational RV32I ADD/SUB/ADDI decode into ALU control and immediate
module alu_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [3:0]      alu_ctrl_o,
  output logic            use_imm_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic r_add, r_sub, i_add;
  logic unused_fields;
  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  assign unused_fields = ^{instr_i[19:15], instr_i[11:7]};
  assign r_add = op == OP_RTYPE && f3 == 3'b000 && f7 == 7'b0000000;
  assign r_sub = op == OP_RTYPE && f3 == 3'b000 && f7 == F7_SUB;
  assign i_add = op == OP_ITYPE && f3 == 3'b000;
  assign alu_ctrl_o = r_sub ? ALU_SUB : (r_add || i_add) ? ALU_ADD : ALU_NOP;
  assign use_imm_o = i_add;
  assign imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign illegal_o = !(r_add || r_sub || i_add);
endmodule

// File: rtl/alu_issue.sv
// alu_issue: execute-stage front end; registers ALU operands/control, captures the
// result one cycle later and presents it to writeback with a valid/ready handshake.
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal
);
  state_e state_q;
  logic [XLEN-1:0] a_q, b_q, res_q;
  logic [3:0] ctrl_q;
  logic [RD_W-1:0] rd_q, out_rd_q;
  logic ill_q, out_ill_q, out_valid_q;
  logic [3:0] dec_ctrl;
  logic dec_use_imm, dec_illegal, accept;
  logic [XLEN-1:0] dec_imm;
  alu_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (instr),
    .alu_ctrl_o(dec_ctrl),
    .use_imm_o (dec_use_imm),
    .imm_o     (dec_imm),
    .illegal_o (dec_illegal)
  );
  assign in_ready = state_q == IDLE || (state_q == HOLD && out_ready);
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      ctrl_q <= ALU_NOP;
      rd_q <= '0;
      ill_q <= 1'b0;
      res_q <= '0;
      out_rd_q <= '0;
      out_ill_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_q <= in_valid ? EXEC : IDLE;
        EXEC: begin
          res_q <= ill_q ? '0 : alu_result;
          out_rd_q <= rd_q;
          out_ill_q <= ill_q;
          out_valid_q <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q <= in_valid ? EXEC : IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Illegal encodings drive a zeroed NOP into the ALU
      if (accept) begin
        a_q <= dec_illegal ? '0 : rs1_data;
        b_q <= dec_illegal ? '0 : dec_use_imm ? dec_imm : rs2_data;
        ctrl_q <= dec_ctrl;
        rd_q <= instr[11:7];
        ill_q <= dec_illegal;
      end
    end
  end
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_ctrl = ctrl_q;
  assign out_valid = out_valid_q;
  assign out_result = res_q;
  assign out_rd = out_rd_q;
  assign out_illegal = out_ill_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue with a behavioural ALU on the operand bus
module tb_alu_issue;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_illegal;
  logic [31:0] instr = '0, rs1 = '0, rs2 = '0, alu_a, alu_b, alu_result, out_result;
  logic [3:0] alu_ctrl;
  logic [4:0] out_rd;
  int checks = 0, errors = 0, cyc = 0;
  bit seen = 1'b0;
  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
    logic [3:0]  ctrl;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  alu_issue #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_data(rs1), .rs2_data(rs2), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  assign alu_result = alu_ctrl == 4'b0010 ? alu_a + alu_b : alu_ctrl == 4'b0110 ? alu_a - alu_b : 32'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rt(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] it(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, 5'd1, f3, rd, op};
  endfunction

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] sx;
    sx = {{20{i[31]}}, i[31:20]};
    e.rd = i[11:7];
    e.cyc = cyc;
    e.ill = 1'b0;
    if (i[6:0] == 7'b0110011 && i[14:12] == 3'b000 && i[31:25] == 7'b0000000) begin
      e.ctrl = 4'b0010; e.res = a + b;
    end else if (i[6:0] == 7'b0110011 && i[14:12] == 3'b000 && i[31:25] == 7'b0100000) begin
      e.ctrl = 4'b0110; e.res = a - b;
    end else if (i[6:0] == 7'b0010011 && i[14:12] == 3'b000) begin
      e.ctrl = 4'b0010; e.res = a + sx;
    end else begin
      e.ctrl = 4'b0000; e.res = 32'h0; e.ill = 1'b1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      seen = 1'b0;
    end else begin
      if (sb.size() > 0 && sb[$].cyc == cyc - 1) chk("exec_ctrl", {28'h0, alu_ctrl}, {28'h0, sb[$].ctrl});
      if (out_valid) begin
        if (sb.size() == 0) chk("spurious_valid", {31'h0, out_valid}, 32'h0);
        else begin
          if (!seen) begin
            chk("latency", cyc - sb[0].cyc, 32'd2);
            seen = 1'b1;
          end
          if (out_ready) begin
            exp_t e;
            e = sb.pop_front();
            chk("result", out_result, e.res);
            chk("rd", {27'h0, out_rd}, {27'h0, e.rd});
            chk("illegal", {31'h0, out_illegal}, {31'h0, e.ill});
            seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(instr, rs1, rs2));
    end
  end

  task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    bit got = 1'b0;
    instr = i; rs1 = a; rs2 = b; in_valid = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = in_ready;
    end
    if (!got) chk("accept_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() > 0; n++) @(negedge clk);
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_ctrl", {28'h0, alu_ctrl}, 32'h0);
    chk("rst_rd", {27'h0, out_rd}, 32'h0);
    chk("rst_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    send(rt(7'h00, 3'b000, 5'd3), 32'd5, 32'd7);
    drain();
    send(rt(7'h20, 3'b000, 5'd4), 32'd0, 32'd1);
    send(rt(7'h00, 3'b000, 5'd5), 32'hFFFF_FFFF, 32'd1);
    drain();
    send(it(12'hFFF, 3'b000, 5'd6, 7'b0010011), 32'd10, 32'd99);
    send(it(12'h7FF, 3'b000, 5'd7, 7'b0010011), 32'd10, 32'd99);
    drain();
    send(rt(7'h00, 3'b110, 5'd8), 32'd3, 32'd5);
    send(it(12'h004, 3'b000, 5'd9, 7'b0000011), 32'd3, 32'd5);
    drain();
    // writeback stall: result must hold while out_ready is low
    out_ready = 1'b0;
    send(rt(7'h00, 3'b000, 5'd10), 32'd100, 32'd23);
    for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("hold_valid", {31'h0, out_valid}, 32'h1);
      chk("hold_result", out_result, 32'd123);
      chk("hold_rd", {27'h0, out_rd}, 32'd10);
      chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1; instr = rt(7'h20, 3'b000, 5'd11); rs1 = 32'd50; rs2 = 32'd8; in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid_drop", {31'h0, out_valid}, 32'h0);
    drain();
    // reset while the op sits in EXEC
    send(rt(7'h00, 3'b000, 5'd12), 32'd1, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", {31'h0, out_valid}, 32'h0);
    chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("abort_quiet", {31'h0, out_valid}, 32'h0);
    end
    send(rt(7'h00, 3'b000, 5'd13), 32'd40, 32'd2);
    drain();
    for (int n = 0; n < 8; n++) begin
      logic [31:0] a, b, i;
      a = $urandom; b = $urandom;
      i = n % 3 == 0 ? rt(7'h00, 3'b000, 5'(n)) : n % 3 == 1 ? rt(7'h20, 3'b000, 5'(n)) : it(12'($urandom), 3'b000, 5'(n), 7'b0010011);
      send(i, a, b);
    end
    drain();
    chk("sb_empty", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
